sw_key_input_port: RTL and testbench
====================================

# sw_key_input_port

Memory-mapped input peripheral that brings the DE-series slide switches and pushbuttons into the soft-core's data bus. It performs the opposite direction to the HEX/LEDR output block: board pins in, CPU reads out. It synchronizes and debounces SW[9:0] and KEY[3:0], captures KEY press edges, and raises a maskable interrupt. It sits beside the output I/O block on the same bus and is clocked from CLOCK_50.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new input level (10 ms at 50 MHz); must be ≥ 2.
- CLOCK_50  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- SW  input  10  raw slide switches, asynchronous to CLOCK_50.
- KEY  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous.
- address  input  2  word offset of the register to access.
- read  input  1  read strobe, one cycle per access.
- write  input  1  write strobe, one cycle per access.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request, level, active-high.

## Operation
- Register map: 0 = SW_DATA (bits 9:0 debounced SW); 1 = KEY_DATA (bits 3:0 debounced, pressed = 1); 2 = KEY_EDGE (sticky press flags, write-1-to-clear); 3 = KEY_MASK (bits 3:0 interrupt enables, read/write). Unused readdata bits are 0.
- Synchronizer: each of the 14 input bits passes through two flip-flops. KEY bits are inverted after synchronization so that internal 1 = pressed.
- Debounce per bit: a counter increments each cycle the synchronized bit differs from the stable bit and clears to 0 when they match. On the cycle where counter == DEBOUNCE_CYCLES-1 and the bits still differ, the stable bit takes the synchronized value and the counter clears. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never changes the stable bit.
- Edge capture: KEY_EDGE[i] sets on the same clock edge that stable KEY[i] goes 0→1. It stays set until cleared. Release (1→0) sets nothing.
- Clear: a write to address 2 clears each KEY_EDGE bit whose writedata bit is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- Writes to addresses 0 and 1 are ignored. A write to address 3 loads KEY_MASK from writedata[3:0].
- irq = |(KEY_EDGE & KEY_MASK). It is decoded from registers only, so it is glitch-free.
- read and write in the same cycle: both take effect. The read returns the pre-write value.

## Timing
- Reset values: readdata = 0, irq = 0. All synchronizer flops, stable bits, counters, KEY_EDGE and KEY_MASK = 0.
- Reset mid-debounce discards the counter progress. After release, inputs are re-qualified from scratch.
- Input latency: a pin change sampled at edge k appears in the synchronized bit at edge k+1. The stable bit updates at edge k+DEBOUNCE_CYCLES+1, provided the pin held its value throughout.
- Read latency: 1 cycle. With read asserted at edge n, readdata is valid after edge n+1 and holds until the next read.
- A write takes effect at the edge where write is sampled, and irq reflects it one cycle later.
- The counter width is $clog2(DEBOUNCE_CYCLES), and the counter never wraps.

## Structure
- Shared package: the register offset constants (SW_DATA, KEY_DATA, KEY_EDGE, KEY_MASK) and the bus data width. The CPU-side decoder and the output I/O block use the same constants.
- Sub-module `input_debounce`: one bit, parameterized by DEBOUNCE_CYCLES, containing the 2-FF synchronizer, the counter and the stable bit. It is instantiated 14 times via generate.
- The top of this block holds only the edge/mask registers, the read mux and the irq logic.

## Test plan
Benches run with DEBOUNCE_CYCLES = 4.
- Reset with SW = 10'h3FF and KEY = 4'hF held: read address 0 → 0 until 6 cycles after reset release, then 0x3FF.
- Pulse KEY[1] low for 3 cycles: KEY_DATA and KEY_EDGE stay 0. Hold KEY[1] low for 10 cycles: KEY_DATA = 0x2 and KEY_EDGE = 0x2. Release the key: KEY_DATA = 0 and KEY_EDGE stays 0x2.
- Write KEY_MASK = 0x2, then press KEY[1]: irq rises one cycle after KEY_EDGE[1] sets. Write 0x2 to address 2: KEY_EDGE = 0 and irq drops the next cycle.
- Issue the KEY_EDGE clear write on the exact cycle KEY[3]'s edge sets: KEY_EDGE[3] remains 1.
- Toggle SW[0] every 2 cycles for 40 cycles, then hold it at 1: SW_DATA[0] stays 0 during toggling and becomes 1 6 cycles after the hold starts.
- Assert Reset for 1 cycle while KEY[0] is mid-debounce (counter at 2): all registers, readdata and irq are 0. KEY[0] needs a full 4 stable cycles before it is accepted.

Source files
------------

// File: rtl/sw_key_input_port_pkg.sv
// Shared register map and bus types for the board-input peripheral.
// The CPU-side decoder and the output I/O block use the same offsets.
package sw_key_input_port_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned NUM_SW  = 10;
  localparam int unsigned NUM_KEY = 4;
  localparam int unsigned NUM_IN  = NUM_SW + NUM_KEY;

  typedef enum logic [ADDR_W-1:0] {
    SW_DATA  = 2'd0,
    KEY_DATA = 2'd1,
    KEY_EDGE = 2'd2,
    KEY_MASK = 2'd3
  } reg_addr_e;

  typedef struct packed {
    logic              rd;
    logic              wr;
    reg_addr_e         addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sw_key_input_port_debounce.sv
// One input bit: 2-FF synchronizer, optional inversion, and a stability
// counter that only accepts a new level after DEBOUNCE_CYCLES differing samples.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter runs only while the synchronized bit disagrees; it tops out at CNT_LAST.
  always_comb begin
    sync_d   = {sync_q[0], din};
    sample   = sync_q[1] ^ INVERT;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sample != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sample;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_c = stable_d & ~stable_q;
  end

  assign dout = stable_q;

endmodule

// File: rtl/sw_key_input_port.sv
// Memory-mapped slide-switch / pushbutton input port: debounced levels,
// sticky press flags with write-1-to-clear, and a maskable level interrupt.
module sw_key_input_port
  import sw_key_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic [NUM_IN-1:0]  raw_in;
  logic [NUM_IN-1:0]  stable_in;
  logic [NUM_IN-1:0]  rise_in;
  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_KEY-1:0] key_stable;
  logic [NUM_KEY-1:0] key_rise;
  logic [NUM_KEY-1:0] key_clr;
  bus_req_t           req;
  logic               unused_bits;

  logic [NUM_KEY-1:0] key_edge_q, key_edge_d;
  logic [NUM_KEY-1:0] key_mask_q, key_mask_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               irq_q, irq_d;

  always_comb begin
    raw_in     = {KEY, SW};
    sw_stable  = stable_in[NUM_SW-1:0];
    key_stable = stable_in[NUM_IN-1:NUM_SW];
    key_rise   = rise_in[NUM_IN-1:NUM_SW];
    req.rd     = read;
    req.wr     = write;
    req.addr   = reg_addr_e'(address);
    req.wdata  = writedata;
  end

  // KEY pins are active-low; those instances invert so internal 1 = pressed.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (gi >= NUM_SW)
    ) u_db (
      .clk   (CLOCK_50),
      .rst   (Reset),
      .din   (raw_in[gi]),
      .dout  (stable_in[gi]),
      .rise_c(rise_in[gi])
    );
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      key_edge_q <= '0;
      key_mask_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      key_edge_q <= key_edge_d;
      key_mask_q <= key_mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // A new press wins over a same-cycle clear; reads see pre-write register values.
  always_comb begin
    key_clr    = '0;
    key_mask_d = key_mask_q;
    readdata_d = readdata_q;
    if (req.wr && req.addr == KEY_EDGE) key_clr = req.wdata[NUM_KEY-1:0];
    if (req.wr && req.addr == KEY_MASK) key_mask_d = req.wdata[NUM_KEY-1:0];
    key_edge_d = (key_edge_q & ~key_clr) | key_rise;
    if (req.rd) begin
      case (req.addr)
        SW_DATA:  readdata_d = DATA_W'(sw_stable);
        KEY_DATA: readdata_d = DATA_W'(key_stable);
        KEY_EDGE: readdata_d = DATA_W'(key_edge_q);
        KEY_MASK: readdata_d = DATA_W'(key_mask_q);
        default:  readdata_d = '0;
      endcase
    end
    irq_d = |(key_edge_q & key_mask_q);
  end

  always_comb begin
    unused_bits = ^{rise_in[NUM_SW-1:0], req.wdata[DATA_W-1:NUM_KEY]};
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sw_key_input_port.sv
// Directed and randomized bench for sw_key_input_port with DEBOUNCE_CYCLES = 4,
// compared every cycle against a sample-window reference model.
module tb_sw_key_input_port;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int hold   = 0;

  // Reference model state: pin history, last DC synchronized samples per bit.
  logic [13:0]   m_p1, m_p2, m_stable, t_samp, t_new;
  logic [DC-1:0] m_hist [14];
  logic [3:0]    m_edge, m_mask, t_clr;
  logic [31:0]   m_rd;
  logic          m_irq;

  sw_key_input_port #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .SW       (SW),
    .KEY      (KEY),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // A level is accepted once the last DC synchronized samples all disagree with it.
  task automatic model_tick();
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0;
      m_edge = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < 14; i++) m_hist[i] = '0;
    end else begin
      t_samp = {~m_p2[13:10], m_p2[9:0]};
      t_new  = m_stable;
      for (int i = 0; i < 14; i++) begin
        m_hist[i] = {m_hist[i][DC-2:0], t_samp[i]};
        if (m_hist[i] == {DC{~m_stable[i]}}) t_new[i] = ~m_stable[i];
      end
      if (read) begin
        case (address)
          2'd0:    m_rd = {22'b0, m_stable[9:0]};
          2'd1:    m_rd = {28'b0, m_stable[13:10]};
          2'd2:    m_rd = {28'b0, m_edge};
          default: m_rd = {28'b0, m_mask};
        endcase
      end
      m_irq  = |(m_edge & m_mask);
      t_clr  = (write && address == 2'd2) ? writedata[3:0] : 4'b0;
      m_edge = (m_edge & ~t_clr) | (t_new[13:10] & ~m_stable[13:10]);
      if (write && address == 2'd3) m_mask = writedata[3:0];
      m_p2 = m_p1;
      m_p1 = {KEY, SW};
      m_stable = t_new;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check("model_readdata", readdata, m_rd);
    check("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus(input logic r, input logic w, input logic [1:0] a, input logic [31:0] wd);
    read = r; write = w; address = a; writedata = wd;
  endtask

  initial begin
    rst = 1'b1; SW = 10'h3FF; KEY = 4'hF;
    bus(1'b0, 1'b0, 2'd0, 32'h0);
    repeat (3) step();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // Switches held high through reset are accepted only after full qualification.
    rst = 1'b0;
    bus(1'b1, 1'b0, 2'd0, 32'h0);
    repeat (6) step();
    check("sw_before_qual", readdata, 32'h0);
    step();
    check("sw_after_qual", readdata, 32'h3FF);

    // Short KEY[1] pulse is rejected.
    KEY = 4'b1101;
    repeat (3) step();
    KEY = 4'hF;
    repeat (8) step();
    address = 2'd1; step();
    check("short_pulse_data", readdata, 32'h0);
    address = 2'd2; step();
    check("short_pulse_edge", readdata, 32'h0);

    // Long press sets data and edge; release keeps the sticky edge.
    KEY = 4'b1101;
    repeat (10) step();
    address = 2'd1; step();
    check("press_data", readdata, 32'h2);
    address = 2'd2; step();
    check("press_edge", readdata, 32'h2);
    KEY = 4'hF;
    repeat (8) step();
    address = 2'd1; step();
    check("release_data", readdata, 32'h0);
    address = 2'd2; step();
    check("release_edge", readdata, 32'h2);

    // Interrupt path: clear, mask, press, clear again.
    bus(1'b0, 1'b1, 2'd2, 32'h2); step();
    bus(1'b0, 1'b1, 2'd3, 32'h2); step();
    bus(1'b1, 1'b0, 2'd3, 32'h0); step();
    check("mask_readback", readdata, 32'h2);
    check("irq_idle", 32'(irq), 32'h0);
    KEY = 4'b1101;
    for (int n = 0; n < 20 && irq !== 1'b1; n++) step();
    check("irq_rise", 32'(irq), 32'h1);
    bus(1'b0, 1'b1, 2'd2, 32'h2); step();
    bus(1'b0, 1'b0, 2'd0, 32'h0);
    check("irq_hold", 32'(irq), 32'h1);
    step();
    check("irq_drop", 32'(irq), 32'h0);
    KEY = 4'hF;
    repeat (8) step();

    // Clear issued on the exact cycle KEY[3]'s edge sets: the set wins.
    KEY = 4'b0111;
    repeat (5) step();
    bus(1'b0, 1'b1, 2'd2, 32'hF); step();
    bus(1'b1, 1'b0, 2'd2, 32'h0); step();
    check("set_beats_clear", readdata, 32'h8);
    bus(1'b0, 1'b1, 2'd2, 32'hF); step();
    bus(1'b1, 1'b0, 2'd2, 32'h0); step();
    check("clear_later", readdata, 32'h0);
    KEY = 4'hF;
    repeat (8) step();

    // SW[0] toggling every 2 cycles never qualifies; a hold does.
    SW = 10'h0;
    repeat (10) step();
    bus(1'b1, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      SW = {9'b0, ((i / 2) % 2) == 0};
      step();
      check("sw_toggle", 32'(readdata[0]), 32'h0);
    end
    SW = 10'h1;
    repeat (6) step();
    check("sw_hold_before", readdata, 32'h0);
    step();
    check("sw_hold_after", readdata, 32'h1);

    // Randomized pins and bus traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        SW   = 10'($urandom);
        KEY  = 4'($urandom);
        hold = int'($urandom_range(8, 1));
      end
      hold--;
      bus(1'($urandom), $urandom_range(3, 0) == 0, 2'($urandom), $urandom);
      step();
    end
    bus(1'b0, 1'b0, 2'd0, 32'h0);
    SW = 10'h0; KEY = 4'hF;
    repeat (10) step();

    // Reset while KEY[0] is mid-debounce discards progress.
    bus(1'b0, 1'b1, 2'd3, 32'hF); step();
    bus(1'b0, 1'b0, 2'd0, 32'h0);
    KEY = 4'b1110;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    step();
    rst = 1'b0;
    bus(1'b1, 1'b0, 2'd1, 32'h0);
    repeat (4) step();
    check("requal_before", readdata, 32'h0);
    step();
    check("requal_after", readdata, 32'h1);
    address = 2'd3; step();
    check("midreset_mask", readdata, 32'h0);
    address = 2'd2; step();
    check("requal_edge", readdata, 32'h1);
    check("requal_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
